ex_iter_divider: RTL
====================

Name: ex_iter_divider

Overview:
- Multi-cycle 32-bit radix-2 restoring divider in the EX stage.
- Produces quotient and remainder for signed and unsigned divide/modulo instructions.
- Drives the EX pause request into the pipeline controller while busy; the controller then freezes PC/IF/ID/EX until the result is ready.
- Result is consumed by the EX result mux in the cycle valid_o pulses.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  EX holds high while a divide instruction occupies EX.
- signed_i  input  1  1 = two's-complement operation, 0 = unsigned.
- flush_i  input  1  pipeline flush; aborts any operation.
- dividend_i  input  WIDTH  dividend; sampled only on acceptance.
- divisor_i  input  WIDTH  divisor; sampled only on acceptance.
- pause_req_o  output  1  combinational; to controller pause_ex.
- busy_o  output  1  registered; 1 in ZERO/CALC states.
- valid_o  output  1  registered; one-cycle result strobe.
- quotient_o  output  WIDTH  registered quotient.
- remainder_o  output  WIDTH  registered remainder.

Behaviour:
- Reset: state=IDLE, counter=0, busy_o=0, valid_o=0, quotient_o=0, remainder_o=0. Reset mid-operation discards all work; no valid_o.
- States: IDLE, ZERO, CALC, DONE.
- IDLE:
  - Acceptance is start_i=1 and flush_i=0.
  - On acceptance, latch operand magnitudes (negated if signed_i and MSB set), latch the quotient sign (dividend MSB xor divisor MSB, signed only) and remainder sign (dividend MSB, signed only), and clear the counter.
  - Go to ZERO if divisor_i==0, else CALC.
- CALC:
  - Each cycle: shift {rem,quo} left 1 and trial-subtract the divisor magnitude from the (WIDTH+1)-bit partial remainder.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore.
  - Counter increments each cycle; after the WIDTH-th iteration (counter==WIDTH-1), go to DONE.
- ZERO: one cycle; go to DONE with quotient = all ones and remainder = raw dividend.
- DONE:
  - valid_o=1 for exactly this cycle.
  - quotient_o/remainder_o are updated on entry, with sign fixup (two's-complement negate where the latched sign is set).
  - Next state IDLE unconditionally.
- Outputs quotient_o/remainder_o hold their value until the next DONE or reset.
- pause_req_o = (IDLE and start_i and not flush_i) or ZERO or CALC. It is 0 in DONE so the pipeline advances on the valid cycle.
- Latency:
  - Acceptance in cycle 0.
  - Normal divide: CALC in cycles 1..WIDTH, valid_o in cycle WIDTH+1 (33).
  - Divide by zero: valid_o in cycle 2.
- flush_i=1 in any state: next state IDLE, valid_o=0 next cycle, result registers unchanged, pause_req_o forced 0 that cycle. Flush has priority over start_i and over DONE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic; no special case.
- start_i still high in the cycle after DONE (next instruction in EX): treated as a new acceptance.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE on acceptance, if divisor !=0 and |dividend| < |divisor|, enter ZERO-style shortcut path. Result is quotient 0 and remainder = raw dividend, valid_o in cycle 2, pause_req_o high for cycles 0-1 only.
- Undefined: such operands take the full 32-iteration path; results are identical and only latency differs.

Test Plan:
- Unsigned 100/7, start_i held -> pause_req_o high cycles 0-32; valid_o at cycle 33 with q=14, r=2; pause_req_o=0 in cycle 33.
- Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Unsigned same operands -> q=0x7FFFFFFC, r=1.
- Divide by zero, dividend 0x1234 -> valid_o at cycle 2, q=0xFFFFFFFF, r=0x1234.
- Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0 at cycle 33.
- flush_i pulse at cycle 10 of a divide -> IDLE at cycle 11, no valid_o; prior results unchanged. Same with rst at cycle 10 -> all outputs 0.
- Back-to-back divides (start_i stays 1 after DONE) -> second valid_o 34 cycles after first. With DIV_EARLY_OUT_EN, 3/10 unsigned -> valid_o at cycle 2, q=0, r=3.

Source files
------------

// File: rtl/ex_iter_divider.sv
// EX-stage 32-bit radix-2 restoring divider (signed/unsigned quotient and remainder).
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| skips iteration and takes the short path.
module ex_iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             pause_req_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_CALC, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_short_q;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_short;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_fix_quo;
    logic [WIDTH-1:0] w_fix_rem;

    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_a_mag    = (signed_i && dividend_i[WIDTH-1]) ? ('0 - dividend_i) : dividend_i;
    assign w_b_mag    = (signed_i && divisor_i[WIDTH-1])  ? ('0 - divisor_i)  : divisor_i;
    assign w_last     = (r_cnt == LAST_CNT);

`ifdef DIV_EARLY_OUT_EN
    assign w_short = w_div_zero || (w_a_mag < w_b_mag);
`else
    assign w_short = w_div_zero;
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};

    always_comb begin
        w_step_rem = w_diff[WIDTH-1:0];
        w_step_quo = {r_quo[WIDTH-2:0], 1'b1};
        if (w_diff[WIDTH]) begin
            w_step_rem = w_trial[WIDTH-1:0];
            w_step_quo = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    assign w_fix_quo = r_q_neg ? ('0 - w_step_quo) : w_step_quo;
    assign w_fix_rem = r_r_neg ? ('0 - w_step_rem) : w_step_rem;

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) w_next = w_short ? S_ZERO : S_CALC;
                S_ZERO: w_next = S_DONE;
                S_CALC: if (w_last) w_next = S_DONE;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_raw       <= '0;
            r_short_q   <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_ZERO) || (w_next == S_CALC);
            r_valid <= (w_next == S_DONE);
            if (w_accept) begin
                r_rem     <= '0;
                r_quo     <= w_a_mag;
                r_div     <= w_b_mag;
                r_raw     <= dividend_i;
                r_short_q <= w_div_zero ? '1 : '0;
                r_q_neg   <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                r_r_neg   <= signed_i && dividend_i[WIDTH-1];
                r_cnt     <= '0;
            end else if (r_state == S_CALC && !flush_i) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + 1'b1;
            end
            // Short path results bypass sign fixup: the raw dividend already carries its sign.
            if (!flush_i && r_state == S_ZERO) begin
                r_quotient  <= r_short_q;
                r_remainder <= r_raw;
            end else if (!flush_i && r_state == S_CALC && w_last) begin
                r_quotient  <= w_fix_quo;
                r_remainder <= w_fix_rem;
            end
        end
    end

    assign pause_req_o = w_accept || (!flush_i && (r_state == S_ZERO || r_state == S_CALC));
    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;

endmodule
